packet_rr_arbiter: RTL and testbench
====================================

Name: packet_rr_arbiter

Overview:
- Work-conserving, packet-aware round-robin arbiter that shares one AXI-Stream master among NUM_REQ requester streams.
- Sits upstream of the crossbar/kernel datapath in the map-inflation pipeline.
- The grant is held for a whole packet, delimited by tlast. The arbiter skips idle requesters rather than stalling on them.
- A per-packet idle watchdog releases grants held by stalled requesters.

Parameters:
NUM_REQ, 3, number of requester streams (>=2)
DATA_WIDTH, 18, payload width
ID_WIDTH, 2, width of m_axis_tid; must satisfy 2**ID_WIDTH >= NUM_REQ
IDLE_TIMEOUT, 16, consecutive no-valid cycles mid-packet before forced release (>=1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
s_axis_tvalid  in  NUM_REQ  per-requester valid
s_axis_tdata  in  DATA_WIDTH*NUM_REQ  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tlast  in  NUM_REQ  per-requester end-of-packet
s_axis_tready  out  NUM_REQ  per-requester ready (combinational)
m_axis_tvalid  out  1  registered output valid
m_axis_tdata  out  DATA_WIDTH  registered output data
m_axis_tlast  out  1  registered output last
m_axis_tid  out  ID_WIDTH  index of source requester
m_axis_tready  in  1  downstream ready
err_timeout  out  1  sticky flag; set on forced release, cleared only by reset
grant_active  out  1  high while in state BUSY

Behaviour:
- Reset (async, rstn=0): state=IDLE, rr_ptr=0, grant=0, idle_cnt=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, err_timeout=0. s_axis_tready=0 while in reset.
- Reset asserted mid-packet: all state is dropped immediately. The registered beat is lost and there is no partial-packet recovery.
- FSM IDLE:
  - s_axis_tready=0.
  - If any s_axis_tvalid is high, select the first valid index scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ. Register it as grant and move to BUSY.
  - Arbitration costs 1 cycle: valid seen at edge N -> tready visible after edge N, first beat captured at edge N+1, m_axis_tvalid high after edge N+1.
- FSM BUSY:
  - s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready. All other tready bits are 0.
  - Beat accept (tvalid[grant] && tready[grant]): load m_axis_tdata/tlast from requester grant, set m_axis_tid=grant and m_axis_tvalid=1. Otherwise, if m_axis_tready, clear m_axis_tvalid.
  - Full throughput: 1 beat/cycle while downstream ready stays high.
  - Accepted beat with tlast=1: go to IDLE, rr_ptr <= (grant+1) mod NUM_REQ.
  - idle_cnt counts cycles with tvalid[grant]=0 and resets to 0 on any valid cycle.
  - idle_cnt reaching IDLE_TIMEOUT-1 on a no-valid cycle forces release on that cycle's edge: go to IDLE, rr_ptr <= grant+1, err_timeout <= 1. The downstream packet stays unterminated; no tlast is synthesized.
- Output stage: m_axis_* are held stable while m_axis_tvalid && !m_axis_tready (AXI-S rule). m_axis_tid always matches the data beat.
- Simultaneous events:
  - Last beat accept and a new request in the same cycle: the new arbitration still passes through IDLE, so there is a 1-cycle bubble between packets.
  - Last beat accept coinciding with timeout: the last beat wins and err_timeout is not set.
- Single requester active: it is re-granted repeatedly with a 1-cycle gap between packets.
- Wrap: rr_ptr = NUM_REQ-1 advances to 0.

Decomposition:
- Shared package (map_inflation_pkg): FSM state encoding (ST_IDLE, ST_BUSY), default widths, clog2 helper for ID_WIDTH/counter sizing.
- Sub-module rr_pick:
  - Combinational rotating-priority encoder.
  - Inputs: req vector, rr_ptr. Outputs: index, any.
  - Reusable by later schedulers.

Test Plan:
- Reset, then requesters 0/1/2 each send a 2-beat packet (0x10001/0x10002L, 0x20001/0x20002L, 0x30001/0x30002L) with ready=1.
  - Output order 0x10001,0x10002,0x20001,0x20002,0x30001,0x30002; tid 0,0,1,1,2,2; tlast on beats 2/4/6; 1-cycle gap between packets.
- Only requesters 0 and 2 valid, rr_ptr=1.
  - Requester 2's packet is emitted first, then requester 0's; requester 1 is never stalled on; err_timeout stays 0.
- Grant to 1 on a 4-beat packet, toggle m_axis_tready every cycle.
  - All 4 beats emitted in order with data/tid held stable during stalls; requester 0/2 tready stay 0 until tlast is accepted.
- Requester 0 sends 1 beat without tlast, then drops valid for 16 cycles.
  - Grant is released exactly at cycle 16; err_timeout=1 and stays set.
  - Requester 1's pending packet is granted next.
- Assert rstn=0 mid-packet with m_axis_tvalid=1.
  - All outputs go to 0 immediately and asynchronously; after release the first grant goes to requester 0 (rr_ptr=0).
- Random valid/tlast/ready for 500 cycles against a scoreboard.
  - No interleaving of beats from different tid within a packet; per-requester data order is preserved; no beat is lost or duplicated.

Source files
------------

// File: rtl/map_inflation_pkg.sv
// Shared definitions for the map-inflation pipeline schedulers.
// Contents:
//   DEF_*        default widths used by blocks in this pipeline
//   arb_state_e  packet arbiter FSM state encoding
//   clog2_min1   ceil(log2(value)), never less than 1 (counter/index sizing)
package map_inflation_pkg;

    localparam int unsigned DEF_NUM_REQ      = 3;
    localparam int unsigned DEF_DATA_WIDTH   = 18;
    localparam int unsigned DEF_ID_WIDTH     = 2;
    localparam int unsigned DEF_IDLE_TIMEOUT = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
// Scans req_i starting at index ptr_i upward, wrapping to 0, and returns the
// first requesting index.
// Ports:
//   req_i  request vector, one bit per requester
//   ptr_i  index holding highest priority this cycle (must be < NUM_REQ)
//   idx_o  selected index (0 when no request)
//   any_o  high when at least one request is present
module rr_pick #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [ID_WIDTH-1:0] idx_o,
    output logic                any_o
);

    logic                hi_found;
    logic                lo_found;
    logic [ID_WIDTH-1:0] hi_idx;
    logic [ID_WIDTH-1:0] lo_idx;

    // The wrapped scan equals "lowest request at or above ptr, otherwise the
    // lowest request overall", which avoids a variable-indexed rotation.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (req_i[j]) begin
                if (!hi_found && (32'(ptr_i) <= j)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_WIDTH'(j);
                end
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = ID_WIDTH'(j);
                end
            end
        end
        any_o = lo_found;
        idx_o = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Packet-aware, work-conserving round-robin arbiter: NUM_REQ AXI-Stream
// requesters share one registered AXI-Stream master. A grant is held until the
// requester's tlast beat is accepted, or until the requester has shown no
// valid for IDLE_TIMEOUT consecutive cycles (forced release, sticky error).
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   s_axis_t*          requester streams; data of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tready      combinational, only the granted bit can be high
//   m_axis_t*          registered master stream; m_axis_tid = source requester
//   err_timeout        sticky, set on forced release, cleared only by reset
//   grant_active       high while a grant is held (BUSY)
module packet_rr_arbiter
    import map_inflation_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ID_WIDTH     = DEF_ID_WIDTH,
    parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            s_axis_tvalid,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] s_axis_tdata,
    input  logic [NUM_REQ-1:0]            s_axis_tlast,
    output logic [NUM_REQ-1:0]            s_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    input  logic                          m_axis_tready,
    output logic                          err_timeout,
    output logic                          grant_active
);

    localparam int unsigned         CNT_WIDTH = clog2_min1(IDLE_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(IDLE_TIMEOUT - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_IDX = ID_WIDTH'(NUM_REQ - 1);

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [CNT_WIDTH-1:0]  idle_cnt_q, idle_cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;
    logic                  err_q, err_d;

    logic                  pick_any;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  busy;
    logic                  room;
    logic                  accept;
    logic [ID_WIDTH-1:0]   next_ptr;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req_i (s_axis_tvalid),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Mux the granted requester's stream.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy     = (state_q == ST_BUSY);
    // Output register can take a beat when empty or draining this cycle.
    assign room     = !m_valid_q || m_axis_tready;
    assign accept   = busy && sel_valid && room;
    assign next_ptr = (grant_q == LAST_IDX) ? '0 : grant_q + ID_WIDTH'(1);

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            s_axis_tready[i] = busy && room && (grant_q == ID_WIDTH'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        idle_cnt_d = idle_cnt_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        m_tid_d    = m_tid_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                // The previous packet's last beat may still be draining.
                if (m_axis_tready) begin
                    m_valid_d = 1'b0;
                end
                if (pick_any) begin
                    grant_d    = pick_idx;
                    idle_cnt_d = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    m_valid_d  = 1'b1;
                    m_data_d   = sel_data;
                    m_last_d   = sel_last;
                    m_tid_d    = grant_q;
                    idle_cnt_d = '0;
                    if (sel_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else begin
                    if (m_axis_tready) begin
                        m_valid_d = 1'b0;
                    end
                    if (sel_valid) begin
                        // Stalled by downstream, not by the requester.
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == CNT_LAST) begin
                        // Stalled requester: drop the grant, packet left open.
                        state_d    = ST_IDLE;
                        rr_ptr_d   = next_ptr;
                        err_d      = 1'b1;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            idle_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_tid_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            idle_cnt_q <= idle_cnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            m_tid_q    <= m_tid_d;
            err_q      <= err_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tid    = m_tid_q;
    assign err_timeout   = err_q;
    assign grant_active  = busy;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Self-checking bench for packet_rr_arbiter: directed scenarios plus a
// randomized run, all compared cycle by cycle with a behavioural model.
module tb_packet_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 18;
    localparam int IW = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    s_vld;
    logic [DW*N-1:0] s_dat;
    logic [N-1:0]    s_lst;
    logic [N-1:0]    s_rdy;
    logic            m_vld;
    logic [DW-1:0]   m_dat;
    logic            m_lst;
    logic [IW-1:0]   m_tid;
    logic            m_rdy;
    logic            err;
    logic            gact;

    packet_rr_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .ID_WIDTH     (IW),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tvalid (s_vld),
        .s_axis_tdata  (s_dat),
        .s_axis_tlast  (s_lst),
        .s_axis_tready (s_rdy),
        .m_axis_tvalid (m_vld),
        .m_axis_tdata  (m_dat),
        .m_axis_tlast  (m_lst),
        .m_axis_tid    (m_tid),
        .m_axis_tready (m_rdy),
        .err_timeout   (err),
        .grant_active  (gact)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Sources: per-requester queue of {last, data} beats still to be sent.
    logic [DW:0]   src_q [N][$];
    logic [DW-1:0] exp_q [N][$];
    bit            shown [N];
    int            seq [N];
    int            gate_pct = 100;
    bit            refill_on = 0;
    int            rdy_mode = 0;  // 0 hold, 1 toggle, 2 random

    // Output handshakes seen by the model.
    logic [DW-1:0] log_data [$];
    int            log_tid [$];
    bit            log_last [$];
    int            log_cyc [$];

    // Behavioural model state.
    bit            md_busy;
    int            md_owner;
    int            md_ptr;
    int            md_quiet;
    bit            md_err;
    bit            md_ov;
    logic [DW-1:0] md_od;
    bit            md_ol;
    int            md_oid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int first_from(input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (s_vld[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        md_busy = 0; md_owner = 0; md_ptr = 0; md_quiet = 0; md_err = 0;
        md_ov = 0; md_od = '0; md_ol = 0; md_oid = 0;
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
            shown[k] = 0;
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (!shown[k] && src_q[k].size() > 0 && $urandom_range(99) < 32'(gate_pct))
                shown[k] = 1;
            s_vld[k] = shown[k];
            if (src_q[k].size() > 0) begin
                s_dat[k*DW +: DW] = src_q[k][0][DW-1:0];
                s_lst[k]          = src_q[k][0][DW];
            end else begin
                s_dat[k*DW +: DW] = '0;
                s_lst[k]          = 1'b0;
            end
        end
    endtask

    task automatic push_beat(input int r, input logic [DW-1:0] d, input bit last);
        src_q[r].push_back({last, d});
    endtask

    task automatic refill();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() < 3) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    push_beat(k, {2'(k + 1), 16'(seq[k])}, b == len - 1);
                    seq[k]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] er;
        for (int k = 0; k < N; k++) er[k] = md_busy && md_owner == k && (!md_ov || m_rdy);
        check_eq("s_tready", 32'(s_rdy), 32'(er));
        check_eq("m_tvalid", 32'(m_vld), 32'(md_ov));
        if (md_ov) begin
            check_eq("m_tdata", 32'(m_dat), 32'(md_od));
            check_eq("m_tlast", 32'(m_lst), 32'(md_ol));
            check_eq("m_tid", 32'(m_tid), 32'(md_oid));
        end
        check_eq("grant_active", 32'(gact), 32'(md_busy));
        check_eq("err_timeout", 32'(err), 32'(md_err));
    endtask

    // One clock of the specification's rules, from the inputs held this cycle.
    task automatic model_advance();
        bit room;
        int j;
        room = !md_ov || m_rdy;
        if (md_ov && m_rdy) begin
            log_data.push_back(md_od);
            log_tid.push_back(md_oid);
            log_last.push_back(md_ol);
            log_cyc.push_back(cyc);
            check_eq("sb_avail", 32'(exp_q[md_oid].size() > 0), 32'd1);
            if (exp_q[md_oid].size() > 0) check_eq("sb_order", 32'(md_od), 32'(exp_q[md_oid].pop_front()));
        end
        if (!md_busy) begin
            if (m_rdy) md_ov = 0;
            j = first_from(md_ptr);
            if (j >= 0) begin
                md_busy = 1; md_owner = j; md_quiet = 0;
            end
        end else if (s_vld[md_owner] && room) begin
            md_ov = 1;
            md_od = s_dat[md_owner*DW +: DW];
            md_ol = s_lst[md_owner];
            md_oid = md_owner;
            md_quiet = 0;
            exp_q[md_owner].push_back(md_od);
            void'(src_q[md_owner].pop_front());
            shown[md_owner] = 0;
            if (md_ol) begin
                md_busy = 0;
                md_ptr = (md_owner + 1) % N;
            end
        end else begin
            if (m_rdy) md_ov = 0;
            if (s_vld[md_owner]) begin
                md_quiet = 0;
            end else begin
                md_quiet++;
                if (md_quiet == TO) begin
                    md_busy = 0; md_ptr = (md_owner + 1) % N; md_err = 1; md_quiet = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        model_advance();
        cyc++;
        @(posedge clk);
        #1;
        if (refill_on) refill();
        if (rdy_mode == 1) m_rdy = ~m_rdy;
        else if (rdy_mode == 2) m_rdy = 1'($urandom_range(1));
        drive_inputs();
    endtask

    task automatic drain(input int limit);
        int n;
        bit pending;
        n = 0;
        pending = 1;
        while (pending && n < limit) begin
            pending = md_busy || md_ov;
            for (int k = 0; k < N; k++) if (src_q[k].size() > 0) pending = 1;
            if (pending) begin
                step();
                n++;
            end
        end
        check_eq("drain_done", 32'(pending), 32'd0);
    endtask

    task automatic clear_log();
        log_data.delete(); log_tid.delete(); log_last.delete(); log_cyc.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] t1_data [6];
        int            t1_tid [6];
        int            n;
        t1_data = '{18'h10001, 18'h10002, 18'h20001, 18'h20002, 18'h30001, 18'h30002};
        t1_tid  = '{0, 0, 1, 1, 2, 2};

        rstn = 1'b0; m_rdy = 1'b1; s_vld = '0; s_dat = '0; s_lst = '0;
        model_reset();
        for (int k = 0; k < N; k++) seq[k] = 0;
        #2;
        check_eq("rst_tvalid", 32'(m_vld), 32'd0);
        check_eq("rst_tdata", 32'(m_dat), 32'd0);
        check_eq("rst_tid", 32'(m_tid), 32'd0);
        check_eq("rst_tready", 32'(s_rdy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // All three requesters with a 2-beat packet each.
        for (int k = 0; k < N; k++) begin
            push_beat(k, {2'(k + 1), 16'h0001}, 0);
            push_beat(k, {2'(k + 1), 16'h0002}, 1);
        end
        drive_inputs();
        drain(100);
        check_eq("t1_count", 32'(log_data.size()), 32'd6);
        if (log_data.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check_eq("t1_data", 32'(log_data[i]), 32'(t1_data[i]));
                check_eq("t1_tid", 32'(log_tid[i]), 32'(t1_tid[i]));
                check_eq("t1_last", 32'(log_last[i]), 32'(i % 2));
                if (i > 0) check_eq("t1_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'((i % 2 == 0) ? 2 : 1));
            end
        end

        // Only 0 and 2 requesting with rr_ptr at 1: requester 2 goes first.
        clear_log();
        push_beat(0, 18'h11111, 1);
        drive_inputs();
        drain(100);
        push_beat(0, 18'h10005, 1);
        push_beat(2, 18'h30005, 1);
        drive_inputs();
        drain(100);
        check_eq("t2_count", 32'(log_data.size()), 32'd3);
        if (log_data.size() == 3) begin
            check_eq("t2_first", 32'(log_tid[1]), 32'd2);
            check_eq("t2_second", 32'(log_tid[2]), 32'd0);
        end
        check_eq("t2_err", 32'(err), 32'd0);

        // 4-beat packet from requester 1 with toggling downstream ready.
        clear_log();
        for (int b = 0; b < 4; b++) push_beat(1, 18'h20011 + 18'(b), b == 3);
        push_beat(0, 18'h10021, 1);
        push_beat(2, 18'h30021, 1);
        m_rdy = 1'b0;
        rdy_mode = 1;
        drive_inputs();
        drain(200);
        rdy_mode = 0;
        m_rdy = 1'b1;
        check_eq("t3_count", 32'(log_data.size()), 32'd6);
        if (log_data.size() == 6) begin
            for (int b = 0; b < 4; b++) begin
                check_eq("t3_data", 32'(log_data[b]), 32'(18'h20011 + 18'(b)));
                check_eq("t3_tid", 32'(log_tid[b]), 32'd1);
            end
        end

        // Stalled requester 0: forced release after 16 idle cycles.
        clear_log();
        push_beat(0, 18'h1AAAA, 0);
        drive_inputs();
        n = 0;
        while (src_q[0].size() > 0 && n < 10) begin
            step();
            n++;
        end
        push_beat(1, 18'h2BBB1, 0);
        push_beat(1, 18'h2BBB2, 1);
        drive_inputs();
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (!gact) break;
        end
        check_eq("t4_release_cycle", 32'(n), 32'd16);
        check_eq("t4_err_set", 32'(err), 32'd1);
        drain(100);
        check_eq("t4_count", 32'(log_data.size()), 32'd3);
        if (log_data.size() == 3) begin
            check_eq("t4_next_tid", 32'(log_tid[1]), 32'd1);
            check_eq("t4_next_data", 32'(log_data[1]), 32'h2BBB1);
        end
        check_eq("t4_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset with a beat held in the output register.
        clear_log();
        m_rdy = 1'b0;
        push_beat(0, 18'h10031, 0);
        push_beat(0, 18'h10032, 0);
        push_beat(0, 18'h10033, 1);
        drive_inputs();
        n = 0;
        while (!md_ov && n < 10) begin
            step();
            n++;
        end
        check_eq("t5_pre_valid", 32'(m_vld), 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("t5_tvalid", 32'(m_vld), 32'd0);
        check_eq("t5_tdata", 32'(m_dat), 32'd0);
        check_eq("t5_tlast", 32'(m_lst), 32'd0);
        check_eq("t5_tid", 32'(m_tid), 32'd0);
        check_eq("t5_grant", 32'(gact), 32'd0);
        check_eq("t5_err", 32'(err), 32'd0);
        check_eq("t5_tready", 32'(s_rdy), 32'd0);
        model_reset();
        drive_inputs();
        @(posedge clk); #1;
        rstn = 1'b1;
        m_rdy = 1'b1;
        push_beat(1, 18'h20041, 1);
        push_beat(0, 18'h10041, 1);
        drive_inputs();
        drain(100);
        check_eq("t5_count", 32'(log_data.size()), 32'd2);
        if (log_data.size() == 2) begin
            check_eq("t5_first_tid", 32'(log_tid[0]), 32'd0);
            check_eq("t5_second_tid", 32'(log_tid[1]), 32'd1);
        end

        // Randomized traffic against the model and scoreboard.
        clear_log();
        refill_on = 1;
        gate_pct = 70;
        rdy_mode = 2;
        for (int c = 0; c < 500; c++) step();
        refill_on = 0;
        gate_pct = 100;
        rdy_mode = 0;
        m_rdy = 1'b1;
        drive_inputs();
        drain(3000);
        n = 0;
        for (int k = 0; k < N; k++) n += exp_q[k].size();
        check_eq("rand_undelivered", 32'(n), 32'd0);
        check_eq("rand_activity", 32'(log_data.size() > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
